// File: rtl/nn_ctrl_pkg.sv
// Shared constants and types for the dense-output-layer sequencer and its
// serial argmax unit.
package nn_ctrl_pkg;

    localparam int N_IN    = 32;
    localparam int IN_W    = 20;
    localparam int N_CLASS = 10;
    localparam int SCORE_W = 28;
    localparam int IDX_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SCAN  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef logic signed [SCORE_W-1:0] score_t;

endpackage

// File: rtl/argmax_serial.sv
// Serial argmax over a captured score bank: one signed strict-greater compare
// per cycle, so ties resolve to the lowest index.
module argmax_serial
    import nn_ctrl_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic [SCORE_W*N_CLASS-1:0] scores_i,
    output logic                       done_o,
    output logic [IDX_W-1:0]           res_idx_o,
    output score_t                     res_score_o
);

    score_t           bank_q [N_CLASS];
    score_t           best_q;
    logic [IDX_W-1:0] best_idx_q;
    logic [IDX_W-1:0] idx_q;
    logic             active_q;

    score_t           cand_s;
    logic             take_s;
    score_t           best_d;
    logic [IDX_W-1:0] best_idx_d;

    // Compare the current bank entry against the running best.
    always_comb begin
        cand_s     = bank_q[idx_q];
        take_s     = 1'b0;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        if (active_q && (cand_s > best_q)) begin
            take_s     = 1'b1;
            best_d     = cand_s;
            best_idx_d = idx_q;
        end else begin
            take_s     = 1'b0;
        end
    end

    // done_o marks the final compare; the result outputs already include it.
    assign done_o      = active_q && (idx_q == IDX_W'(N_CLASS - 1));
    assign res_idx_o   = best_idx_d;
    assign res_score_o = best_d;

    // Bank capture, idx counter and best registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_CLASS; k++) begin
                bank_q[k] <= '0;
            end
            best_q     <= '0;
            best_idx_q <= '0;
            idx_q      <= '0;
            active_q   <= 1'b0;
        end else if (start_i) begin
            for (int k = 0; k < N_CLASS; k++) begin
                bank_q[k] <= scores_i[k*SCORE_W +: SCORE_W];
            end
            best_q     <= scores_i[0 +: SCORE_W];
            best_idx_q <= '0;
            idx_q      <= IDX_W'(1);
            active_q   <= 1'b1;
        end else if (active_q) begin
            if (take_s) begin
                best_q     <= best_d;
                best_idx_q <= best_idx_d;
            end else begin
                best_q     <= best_q;
                best_idx_q <= best_idx_q;
            end
            if (done_o) begin
                active_q <= 1'b0;
            end else begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end else begin
            active_q <= 1'b0;
        end
    end

endmodule

// File: rtl/layer2_argmax_ctrl.sv
// Sequencer for the 32-in / 10-class output layer: accepts a vector, pulses
// the layer, scans the scores and hands the argmax downstream.
module layer2_argmax_ctrl
    import nn_ctrl_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IN_W*N_IN-1:0]       in_data,
    output logic                       lay_valid,
    input  logic                       lay_ready,
    output logic [IN_W*N_IN-1:0]       lay_in,
    input  logic [SCORE_W*N_CLASS-1:0] lay_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [IDX_W-1:0]           out_class,
    output logic [SCORE_W-1:0]         out_score,
    output logic                       busy
);

    state_t                state_q;
    logic                  in_ready_q;
    logic                  busy_q;
    logic                  lay_valid_q;
    logic [IN_W*N_IN-1:0]  lay_in_q;
    logic                  out_valid_q;
    logic [IDX_W-1:0]      out_class_q;
    logic [SCORE_W-1:0]    out_score_q;

    logic                  start_s;
    logic                  scan_done_s;
    logic [IDX_W-1:0]      res_idx_s;
    score_t                res_score_s;

    // lay_ready only counts while waiting on the layer.
    assign start_s = (state_q == ST_WAIT) && lay_ready;

    argmax_serial u_argmax (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_s),
        .scores_i    (lay_out),
        .done_o      (scan_done_s),
        .res_idx_o   (res_idx_s),
        .res_score_o (res_score_s)
    );

    // Control FSM with all handshake outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            lay_valid_q <= 1'b0;
            lay_in_q    <= '0;
            out_valid_q <= 1'b0;
            out_class_q <= '0;
            out_score_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        lay_in_q    <= in_data;
                        lay_valid_q <= 1'b1;
                        in_ready_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end else begin
                        state_q     <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    lay_valid_q <= 1'b0;
                    state_q     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (lay_ready) begin
                        state_q <= ST_SCAN;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_SCAN: begin
                    if (scan_done_s) begin
                        out_valid_q <= 1'b1;
                        out_class_q <= res_idx_s;
                        out_score_q <= res_score_s;
                        state_q     <= ST_DONE;
                    end else begin
                        state_q     <= ST_SCAN;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else begin
                        state_q     <= ST_DONE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    lay_valid_q <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign lay_valid = lay_valid_q;
    assign lay_in    = lay_in_q;
    assign out_valid = out_valid_q;
    assign out_class = out_class_q;
    assign out_score = out_score_q;

endmodule

// File: tb/tb_layer2_argmax_ctrl.sv
// Randomized bench for layer2_argmax_ctrl with a 1-cycle layer model and a
// max-then-first-index argmax reference.
module tb_layer2_argmax_ctrl;

    localparam int N_IN    = 32;
    localparam int IN_W    = 20;
    localparam int N_CLASS = 10;
    localparam int SCORE_W = 28;
    localparam int IDX_W   = 4;

    logic                       clk = 1'b0;
    logic                       rst = 1'b0;
    logic                       in_valid = 1'b0;
    logic                       in_ready;
    logic [IN_W*N_IN-1:0]       in_data = '0;
    logic                       lay_valid;
    logic                       lay_ready = 1'b0;
    logic [IN_W*N_IN-1:0]       lay_in;
    logic [SCORE_W*N_CLASS-1:0] lay_out = '0;
    logic                       out_valid;
    logic                       out_ready = 1'b0;
    logic [IDX_W-1:0]           out_class;
    logic [SCORE_W-1:0]         out_score;
    logic                       busy;

    logic signed [SCORE_W-1:0]  ms [N_CLASS];
    int total = 0;
    int bad   = 0;

    layer2_argmax_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .lay_valid (lay_valid),
        .lay_ready (lay_ready),
        .lay_in    (lay_in),
        .lay_out   (lay_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_score (out_score),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Layer model: ready and scores one cycle after valid.
    always @(posedge clk) begin
        lay_ready <= lay_valid;
        if (lay_valid) begin
            for (int c = 0; c < N_CLASS; c++) begin
                lay_out[c*SCORE_W +: SCORE_W] <= ms[c];
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IN_W*N_IN-1:0] rand_vec();
        logic [IN_W*N_IN-1:0] v;
        for (int k = 0; k < N_IN; k++) begin
            v[k*IN_W +: IN_W] = IN_W'($urandom);
        end
        return v;
    endfunction

    // Reference: largest signed value, then the first index holding it.
    task automatic ref_argmax(output logic [IDX_W-1:0] ci, output logic [SCORE_W-1:0] cs);
        int mx;
        mx = ms[0];
        for (int c = 1; c < N_CLASS; c++) begin
            if (int'(ms[c]) > mx) mx = ms[c];
        end
        ci = '0;
        for (int c = N_CLASS - 1; c >= 0; c--) begin
            if (int'(ms[c]) == mx) ci = IDX_W'(c);
        end
        cs = SCORE_W'(mx);
    endtask

    task automatic do_inference(input string tag, input int hold);
        logic [IN_W*N_IN-1:0] vec;
        logic [IDX_W-1:0]     ec;
        logic [SCORE_W-1:0]   es;
        int cyc;
        bit got;
        ref_argmax(ec, es);
        vec = rand_vec();
        in_data  = vec;
        in_valid = 1'b1;
        out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL %s accept_ready: got %0b want 1", tag, in_ready);
        end
        step();
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0 || lay_valid !== 1'b1 || busy !== 1'b1 || lay_in !== vec) begin
            bad++;
            $display("FAIL %s cycle1: in_ready=%0b lay_valid=%0b busy=%0b lay_in_ok=%0b want 0 1 1 1",
                     tag, in_ready, lay_valid, busy, lay_in === vec);
        end
        cyc = 1;
        got = 1'b0;
        while (!got && cyc < 40) begin
            in_data   = rand_vec();
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            step();
            cyc++;
            if (out_valid === 1'b1) begin
                got = 1'b1;
            end else begin
                total++;
                if (lay_valid !== 1'b0 || lay_in !== vec || in_ready !== 1'b0 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL %s cycle%0d: lay_valid=%0b lay_in_ok=%0b in_ready=%0b busy=%0b want 0 1 0 1",
                             tag, cyc, lay_valid, lay_in === vec, in_ready, busy);
                end
            end
        end
        total++;
        if (!got || cyc != 12) begin
            bad++; $display("FAIL %s latency: got %0d (seen=%0b) want 12", tag, cyc, got);
        end
        total++;
        if (out_class !== ec || out_score !== es) begin
            bad++;
            $display("FAIL %s result: got class=%0d score=%0d want class=%0d score=%0d",
                     tag, out_class, $signed(out_score), ec, $signed(es));
        end
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = rand_vec();
            step();
            total++;
            if (out_valid !== 1'b1 || out_class !== ec || out_score !== es ||
                in_ready !== 1'b0 || lay_in !== vec) begin
                bad++;
                $display("FAIL %s hold%0d: out_valid=%0b class=%0d score=%0d in_ready=%0b want 1 %0d %0d 0",
                         tag, h, out_valid, out_class, $signed(out_score), in_ready, ec, $signed(es));
            end
        end
        out_ready = 1'b1;
        in_valid  = 1'($urandom);
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 ||
            out_class !== ec || out_score !== es || lay_in !== vec) begin
            bad++;
            $display("FAIL %s handshake: out_valid=%0b in_ready=%0b busy=%0b class=%0d want 0 1 0 %0d",
                     tag, out_valid, in_ready, busy, out_class, ec);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(); step(); step();
        rst = 1'b0;
        total++;
        if (in_ready !== 1'b1 || lay_valid !== 1'b0 || lay_in !== '0 || out_valid !== 1'b0 ||
            out_class !== '0 || out_score !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset: in_ready=%0b lay_valid=%0b out_valid=%0b class=%0d score=%0d busy=%0b",
                     in_ready, lay_valid, out_valid, out_class, out_score, busy);
        end
    endtask

    task automatic test_ramp;
        for (int c = 0; c < N_CLASS; c++) ms[c] = SCORE_W'(c * 10);
        do_inference("ramp", 0);
    endtask

    task automatic test_negative;
        for (int c = 0; c < N_CLASS; c++) ms[c] = -28'sd500;
        ms[3] = -28'sd2;
        do_inference("negative", 0);
    endtask

    task automatic test_tie;
        for (int c = 0; c < N_CLASS; c++) ms[c] = '0;
        ms[2] = 28'sd118;
        ms[7] = 28'sd118;
        do_inference("tie", 0);
    endtask

    task automatic test_back_pressure;
        for (int c = 0; c < N_CLASS; c++) ms[c] = SCORE_W'($urandom);
        do_inference("backpressure", 5);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < N_CLASS; c++) ms[c] = SCORE_W'($urandom);
            do_inference("b2b", 0);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < N_CLASS; c++) begin
                if (i[0]) ms[c] = SCORE_W'(int'($urandom_range(0, 3)) - 1);
                else      ms[c] = SCORE_W'($urandom);
            end
            do_inference("random", int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_reset_in_scan;
        int seen;
        for (int c = 0; c < N_CLASS; c++) ms[c] = SCORE_W'(c * 3);
        in_data  = rand_vec();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 1; k < 6; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 ||
            lay_valid !== 1'b0 || lay_in !== '0 || out_class !== '0 || out_score !== '0) begin
            bad++;
            $display("FAIL scan_reset: out_valid=%0b busy=%0b in_ready=%0b lay_valid=%0b class=%0d want 0 0 1 0 0",
                     out_valid, busy, in_ready, lay_valid, out_class);
        end
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (out_valid === 1'b1 || busy === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++; $display("FAIL scan_reset_quiet: got %0d active cycles want 0", seen);
        end
        for (int c = 0; c < N_CLASS; c++) ms[c] = SCORE_W'($urandom);
        do_inference("after_reset", 1);
    endtask

    initial begin
        for (int c = 0; c < N_CLASS; c++) ms[c] = '0;
        test_reset();
        test_ramp();
        test_negative();
        test_tie();
        test_back_pressure();
        test_back_to_back();
        test_random();
        test_reset_in_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
